usb_token_crc5_rx: RTL and testbench

- Endpoint-side receive checker for USB token packets (IN/OUT/SETUP/SOF payload).
- Consumes the post-PID token field bit-serially: 11 payload bits LSB-first, then the 5-bit CRC5 field, with a qualifying strobe per bit.
- Runs the USB CRC5 LFSR over all 16 bits and checks the residual.
- Presents decoded address/endpoint with a done pulse and a pass/fail flag. Sits between the bit unstuffer/NRZI decoder and endpoint token decode; it is the receive counterpart of mod_crc5.

---
 rtl/usb_pkg.sv | 30 +++
 rtl/usb_crc5_lfsr.sv | 37 +++
 rtl/usb_token_crc5_rx.sv | 146 ++++++++++++++
 tb/tb_usb_token_crc5_rx.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// Shared USB definitions: CRC5 constants, token field widths, token receiver
// state encoding and the single-bit CRC5 LFSR step.
package usb_pkg;

  localparam int TOKEN_PAYLOAD_W = 11;
  localparam int CRC5_W          = 5;

  // Generator x^5+x^2+1 with the x^5 term implicit.
  localparam logic [CRC5_W-1:0] CRC5_POLY     = 5'b00101;
  localparam logic [CRC5_W-1:0] CRC5_INIT     = 5'b11111;
  // LFSR value left after a payload plus its inverted CRC field.
  localparam logic [CRC5_W-1:0] CRC5_RESIDUAL = 5'b01100;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PAYLOAD,
    ST_CRC,
    ST_DONE
  } state_e;

  // One serial LFSR step for wire-order bit b.
  function automatic logic [CRC5_W-1:0] crc5_step(input logic [CRC5_W-1:0] crc,
                                                  input logic              b,
                                                  input logic [CRC5_W-1:0] poly);
    logic fb;
    fb = b ^ crc[CRC5_W-1];
    return {crc[CRC5_W-2:0], 1'b0} ^ (fb ? poly : '0);
  endfunction

endpackage

// File: rtl/usb_crc5_lfsr.sv
// Serial USB CRC5 LFSR. init reloads the seed; en steps in data. When both are
// set in one cycle the step is applied on top of the fresh seed, so the first
// bit of a frame can arrive together with the restart. Shared with the token
// transmitter path, which reads crc; the receiver checks crc_next.
module usb_crc5_lfsr
  import usb_pkg::*;
#(
  parameter logic [CRC5_W-1:0] POLY = CRC5_POLY,
  parameter logic [CRC5_W-1:0] INIT = CRC5_INIT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init,
  input  logic              en,
  input  logic              data,
  output logic [CRC5_W-1:0] crc,
  output logic [CRC5_W-1:0] crc_next
);

  logic [CRC5_W-1:0] crc_q, crc_d, base;

  // Next LFSR value: optional reseed followed by an optional step.
  always_comb begin
    base  = init ? INIT : crc_q;
    crc_d = en ? crc5_step(base, data, POLY) : base;
  end

  // LFSR register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) crc_q <= INIT;
    else        crc_q <= crc_d;
  end

  assign crc      = crc_q;
  assign crc_next = crc_d;

endmodule

// File: rtl/usb_token_crc5_rx.sv
// USB token receive checker: takes the 11 post-PID payload bits (LSB-first)
// followed by the 5-bit CRC field, runs the CRC5 LFSR over all 16 bits and
// reports address/endpoint with a done pulse and a residual check.
// Optional build macro: USB_ADDR_FILTER_EN qualifies omatch with idev_addr.
module usb_token_crc5_rx
  import usb_pkg::*;
#(
  parameter logic [CRC5_W-1:0] POLY     = CRC5_POLY,
  parameter logic [CRC5_W-1:0] INIT     = CRC5_INIT,
  parameter logic [CRC5_W-1:0] RESIDUAL = CRC5_RESIDUAL
) (
  input  logic       iclk,
  input  logic       irst_n,
  input  logic       istart,
  input  logic       ivalid,
  input  logic       idata,
  input  logic       iabort,
  input  logic [6:0] idev_addr,
  output logic [6:0] oaddr,
  output logic [3:0] oendp,
  output logic       odone,
  output logic       ocrc_ok,
  output logic       omatch,
  output logic       obusy
);

  state_e                     state_q, state_d;
  logic [3:0]                 count_q, count_d;
  logic [TOKEN_PAYLOAD_W-1:0] payload_q, payload_d;
  logic [6:0]                 addr_q, addr_d;
  logic [3:0]                 endp_q, endp_d;
  logic                       done_q, done_d;
  logic                       crc_ok_q, crc_ok_d;
  logic                       match_q, match_d;

  logic              in_frame, accept_bit, crc_ok_next, match_next;
  logic [CRC5_W-1:0] crc_next, lfsr_crc_unused;

  // Bits are taken only inside a frame; abort discards the bit beside it.
  assign in_frame    = (state_q == ST_PAYLOAD) || (state_q == ST_CRC);
  assign accept_bit  = in_frame && ivalid && !iabort;
  assign crc_ok_next = (crc_next == RESIDUAL);

`ifdef USB_ADDR_FILTER_EN
  assign match_next = crc_ok_next && (payload_q[6:0] == idev_addr);
`else
  logic addr_unused;
  assign addr_unused = ^idev_addr;
  assign match_next  = crc_ok_next;
`endif

  usb_crc5_lfsr #(
    .POLY (POLY),
    .INIT (INIT)
  ) u_lfsr (
    .clk      (iclk),
    .rst_n    (irst_n),
    .init     (istart),
    .en       (istart || accept_bit),
    .data     (idata),
    .crc      (lfsr_crc_unused),
    .crc_next (crc_next)
  );

  // Frame sequencing and next values of all registered outputs.
  always_comb begin
    // NOTE: every signal gets a default here so no path can infer a latch.
    state_d   = state_q;
    count_d   = count_q;
    payload_d = payload_q;
    addr_d    = addr_q;
    endp_d    = endp_q;
    done_d    = 1'b0;
    crc_ok_d  = crc_ok_q;
    match_d   = match_q;

    if (istart) begin
      // Restart from any state; the start cycle carries payload bit 0.
      state_d   = ST_PAYLOAD;
      count_d   = 4'd1;
      payload_d = {idata, {(TOKEN_PAYLOAD_W-1){1'b0}}};
      crc_ok_d  = 1'b0;
      match_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_PAYLOAD, ST_CRC: begin
          if (iabort) begin
            state_d  = ST_IDLE;
            count_d  = 4'd0;
            crc_ok_d = 1'b0;
          end else if (ivalid) begin
            count_d = count_q + 4'd1;
            if (state_q == ST_PAYLOAD) begin
              // LSB-first shift: after 11 bits bit 0 sits in payload[0].
              payload_d = {idata, payload_q[TOKEN_PAYLOAD_W-1:1]};
              if (count_q == 4'd10) state_d = ST_CRC;
            end else if (count_q == 4'd15) begin
              // 16th bit: results appear together with the DONE state.
              state_d  = ST_DONE;
              count_d  = 4'd0;
              done_d   = 1'b1;
              crc_ok_d = crc_ok_next;
              match_d  = match_next;
              addr_d   = payload_q[6:0];
              endp_d   = payload_q[10:7];
            end
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: ;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state_q   <= ST_IDLE;
      count_q   <= 4'd0;
      payload_q <= '0;
      addr_q    <= '0;
      endp_q    <= '0;
      done_q    <= 1'b0;
      crc_ok_q  <= 1'b0;
      match_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every flop samples pre-edge values.
      state_q   <= state_d;
      count_q   <= count_d;
      payload_q <= payload_d;
      addr_q    <= addr_d;
      endp_q    <= endp_d;
      done_q    <= done_d;
      crc_ok_q  <= crc_ok_d;
      match_q   <= match_d;
    end
  end

  assign oaddr   = addr_q;
  assign oendp   = endp_q;
  assign odone   = done_q;
  assign ocrc_ok = crc_ok_q;
  assign omatch  = match_q;
  assign obusy   = in_frame;

endmodule

// File: tb/tb_usb_token_crc5_rx.sv
// Directed bench for usb_token_crc5_rx with hand-computed token vectors.
module tb_usb_token_crc5_rx;

  logic       iclk = 1'b0;
  logic       irst_n = 1'b0;
  logic       istart = 1'b0;
  logic       ivalid = 1'b0;
  logic       idata = 1'b0;
  logic       iabort = 1'b0;
  logic [6:0] idev_addr = 7'h15;
  logic [6:0] oaddr;
  logic [3:0] oendp;
  logic       odone, ocrc_ok, omatch, obusy;

`ifdef USB_ADDR_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] f1, f2, fc;

  usb_token_crc5_rx dut (
    .iclk      (iclk),
    .irst_n    (irst_n),
    .istart    (istart),
    .ivalid    (ivalid),
    .idata     (idata),
    .iabort    (iabort),
    .idev_addr (idev_addr),
    .oaddr     (oaddr),
    .oendp     (oendp),
    .odone     (odone),
    .ocrc_ok   (ocrc_ok),
    .omatch    (omatch),
    .obusy     (obusy)
  );

  always #5 iclk = ~iclk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wire-order frame: payload {endp,addr} LSB-first, then the CRC field
  // written as sent (field[4] goes out first).
  function automatic logic [15:0] mk_frame(input logic [6:0] a, input logic [3:0] e,
                                           input logic [4:0] field);
    logic [15:0] r;
    r[10:0] = {e, a};
    for (int k = 0; k < 5; k++) r[11+k] = field[4-k];
    return r;
  endfunction

  task automatic drive(input logic s, input logic v, input logic d, input logic a);
    istart = s;
    ivalid = v;
    idata  = d;
    iabort = a;
  endtask

  // Drive bits first..last on successive cycles, optionally with random gaps.
  task automatic send_bits(input logic [15:0] f, input int first, input int last,
                           input int max_gap);
    int g;
    for (int i = first; i <= last; i++) begin
      if (max_gap > 0 && i > first) begin
        g = int'($urandom_range(0, 32'(max_gap)));
        repeat (g) begin
          @(negedge iclk);
          drive(1'b0, 1'b0, 1'($urandom), 1'b0);
        end
      end
      @(negedge iclk);
      drive(i == 0, 1'b1, f[i], 1'b0);
    end
  endtask

  // Idle the inputs, check the DONE cycle, then check odone drops.
  task automatic finish_frame(input string tag, input logic ok, input logic m,
                              input logic [6:0] a, input logic [3:0] e);
    @(negedge iclk);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check({tag, ".done"},   16'(odone),   16'd1);
    check({tag, ".crc_ok"}, 16'(ocrc_ok), 16'(ok));
    check({tag, ".match"},  16'(omatch),  16'(m));
    check({tag, ".addr"},   16'(oaddr),   16'(a));
    check({tag, ".endp"},   16'(oendp),   16'(e));
    check({tag, ".busy"},   16'(obusy),   16'd0);
    @(negedge iclk);
    check({tag, ".done_drop"}, 16'(odone),   16'd0);
    check({tag, ".ok_held"},   16'(ocrc_ok), 16'(ok));
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".addr"},   16'(oaddr),   16'd0);
    check({tag, ".endp"},   16'(oendp),   16'd0);
    check({tag, ".done"},   16'(odone),   16'd0);
    check({tag, ".crc_ok"}, 16'(ocrc_ok), 16'd0);
    check({tag, ".match"},  16'(omatch),  16'd0);
    check({tag, ".busy"},   16'(obusy),   16'd0);
  endtask

  initial begin
    f1 = mk_frame(7'h15, 4'hE, 5'b10111);
    f2 = mk_frame(7'h3A, 4'hA, 5'b11100);

    // Reset state.
    #12;
    check_zero("reset");
    @(negedge iclk);
    irst_n = 1'b1;

    // Vector 1: good token.
    send_bits(f1, 0, 15, 0);
    finish_frame("v1", 1'b1, 1'b1, 7'h15, 4'hE);

    // Reset after bit 7: everything clears at once.
    send_bits(f1, 0, 7, 0);
    @(posedge iclk);
    #2;
    check("midrst.busy_before", 16'(obusy), 16'd1);
    irst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check_zero("midrst");
    @(negedge iclk);
    irst_n = 1'b1;
    send_bits(f1, 0, 15, 0);
    finish_frame("v1_post_rst", 1'b1, 1'b1, 7'h15, 4'hE);

    // Vector 2 with random ivalid gaps.
    send_bits(f2, 0, 15, 3);
    finish_frame("v2_gaps", 1'b1, !FILT, 7'h3A, 4'hA);

    // Single-bit corruption at every position.
    for (int p = 0; p < 16; p++) begin
      fc = f1 ^ (16'd1 << p);
      send_bits(fc, 0, 15, 0);
      finish_frame($sformatf("corrupt%0d", p), 1'b0, 1'b0, fc[6:0], fc[10:7]);
    end

    // Back-to-back: istart on the DONE cycle.
    send_bits(f1, 0, 15, 0);
    @(negedge iclk);
    check("b2b.done", 16'(odone), 16'd1);
    check("b2b.crc_ok", 16'(ocrc_ok), 16'd1);
    drive(1'b1, 1'b1, f2[0], 1'b0);
    send_bits(f2, 1, 15, 0);
    finish_frame("b2b_v2", 1'b1, !FILT, 7'h3A, 4'hA);

    // Abort after bit 9, new frame on the next cycle.
    send_bits(f1, 0, 9, 0);
    @(negedge iclk);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge iclk);
    #1;
    check("abort.done", 16'(odone), 16'd0);
    check("abort.busy", 16'(obusy), 16'd0);
    check("abort.crc_ok", 16'(ocrc_ok), 16'd0);
    check("abort.addr_kept", 16'(oaddr), 16'h3A);
    send_bits(f1, 0, 15, 0);
    finish_frame("post_abort", 1'b1, 1'b1, 7'h15, 4'hE);

    // istart mid-frame restarts without a done pulse.
    send_bits(f2, 0, 4, 0);
    send_bits(f1, 0, 0, 0);
    @(posedge iclk);
    #1;
    check("restart.done", 16'(odone), 16'd0);
    check("restart.busy", 16'(obusy), 16'd1);
    send_bits(f1, 1, 15, 0);
    finish_frame("restart_v1", 1'b1, 1'b1, 7'h15, 4'hE);

    // Address filter: other device address.
    idev_addr = 7'h16;
    send_bits(f1, 0, 15, 0);
    finish_frame("filter16", 1'b1, !FILT, 7'h15, 4'hE);
    idev_addr = 7'h15;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
